axi_llc_w_line_splitter: RTL and testbench
==========================================

Name: axi_llc_w_line_splitter

Overview:
Upstream neighbour of the LLC write unit. Takes one AW-level write descriptor per AXI burst and cuts it into cache-line-bounded descriptors, so that no output descriptor's beats cross a cache-line boundary. Only the final piece of each burst carries x_last=1, so the write unit issues exactly one B response per burst. The block sits between the hit/miss stage and the write unit; it is descriptor-only and never sees W data.

Parameters:
AddrWidth, 64, full AXI address width (addr_t = logic [AddrWidth-1:0]).
ByteOffsetLength, 3, log2 of bytes per data word (word = 8 B).
BlockOffsetLength, 3, log2 of words per cache line (line = 64 B at defaults).
desc_t, logic, LLC descriptor type; fields used: a_x_addr, a_x_len, a_x_size, a_x_burst, a_x_id, x_resp, x_last, way_ind.

Ports:
clk_i  in  1  clock, rising edge.
rst_ni  in  1  asynchronous reset, active low.
desc_i  in  desc_t  burst-level descriptor.
desc_valid_i  in  1  valid for desc_i.
desc_ready_o  out  1  ready for desc_i.
desc_o  out  desc_t  line-bounded descriptor to the write unit.
desc_valid_o  out  1  valid for desc_o.
desc_ready_i  in  1  ready from the write unit.

Behaviour:
- One clock domain. Reset is asynchronous and active-low. Reset values: state IDLE, held descriptor '0, desc_valid_o=0. desc_ready_o=1 out of reset (IDLE).
- Constants:
  - LineBytes = 2**(ByteOffsetLength+BlockOffsetLength).
  - offset = a_x_addr[ByteOffsetLength+BlockOffsetLength-1:0].
  - beats_left_in_line = (LineBytes - offset) >> a_x_size. Computed 9 bits wide, no overflow.
- FSM states: IDLE, SPLIT.
- IDLE:
  - desc_ready_o=1, desc_valid_o=0.
  - On desc_valid_i, register desc_i into desc_q and go to SPLIT.
  - First output is visible the cycle after acceptance (1-cycle latency).
- SPLIT output fields:
  - desc_valid_o=1. desc_o = desc_q with a_x_len = piece_len and x_last = last_piece.
  - rem = desc_q.a_x_len+1 (9 bits).
  - FIXED: piece_len = desc_q.a_x_len, last_piece=1. The whole burst stays in one word/line.
  - INCR: piece_len = min(rem, beats_left_in_line) - 1; last_piece = (rem <= beats_left_in_line).
  - WRAP, reserved burst, or a_x_size > ByteOffsetLength: emit a single piece with the original length, x_resp=SLVERR, last_piece=1. The write unit then drains the W beats and returns SLVERR.
  - x_resp already SLVERR on input: forwarded unchanged, still split normally.
- SPLIT handshake (desc_valid_o && desc_ready_i):
  - If not last_piece:
    - desc_q.a_x_addr = (addr with offset cleared) + LineBytes, i.e. next line, word-aligned.
    - desc_q.a_x_len -= piece_len+1.
    - Stay in SPLIT.
  - If last_piece:
    - desc_ready_o=1 in that same cycle.
    - If desc_valid_i, load the new descriptor and stay in SPLIT (back-to-back, no bubble).
    - Otherwise go to IDLE.
- desc_ready_o=0 in SPLIT except during the last-piece handshake cycle.
- Output stability: while desc_valid_o && !desc_ready_i, desc_o holds constant. desc_valid_o never drops without a handshake.
- Address wrap at 2**AddrWidth is modulo; no error is raised.
- Reset mid-burst aborts the split. No partial state survives.
- way_inp/way_ind and a_x_id pass through unchanged on every piece.

Decomposition:
- axi_llc_pkg additions:
  - split_state_e enum {IDLE, SPLIT}.
  - Function beats_to_line_end(offset, size).
- No sub-module; the datapath is one register plus an adder/min. Instantiation site: between hit/miss output and write unit input, replacing a direct connection.
- RTL target ~150 lines. Use FFARN-style registers with reset value '0.

Test Plan:
All cases at defaults (LineBytes=64).
1. INCR addr 0x38, len 3, size 3 → addr 0x38 len 0 x_last 0; then addr 0x40 len 2 x_last 1. Input ready only during the second handshake.
2. INCR addr 0x00, len 15, size 3 → addr 0x00 len 7 last 0; then addr 0x40 len 7 last 1.
3. FIXED addr 0x3C, len 9, size 2 → single piece addr 0x3C len 9 last 1.
4. WRAP addr 0x10, len 3 → single piece len 3 x_resp SLVERR last 1. Also size 4 INCR → SLVERR.
5. desc_ready_i low for 5 cycles mid-split → desc_o stable and valid held. Two bursts queued back-to-back → no idle cycle between the last piece of #1 and the first piece of #2.
6. Assert rst_ni low during SPLIT → desc_valid_o=0 asynchronously. After release, state is IDLE, desc_ready_o=1, and a new burst splits correctly.

Source files
------------

// File: rtl/axi_llc_w_line_splitter_pkg.sv
// Shared types and helpers for the LLC write-path line splitter.
// Holds the descriptor layout, the FSM encoding and the beats-to-line-end arithmetic.
package axi_llc_w_line_splitter_pkg;

    localparam int unsigned AddrWidth         = 64;
    localparam int unsigned IdWidth           = 4;
    localparam int unsigned WayWidth          = 8;
    localparam int unsigned ByteOffsetLength  = 3;
    localparam int unsigned BlockOffsetLength = 3;
    localparam int unsigned OffsetWidth       = ByteOffsetLength + BlockOffsetLength;
    localparam int unsigned LineBytes         = 2 ** OffsetWidth;

    localparam logic [1:0] BurstFixed = 2'b00;
    localparam logic [1:0] BurstIncr  = 2'b01;
    localparam logic [1:0] BurstWrap  = 2'b10;
    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlverr = 2'b10;

    typedef logic [AddrWidth-1:0] addr_t;

    typedef struct packed {
        addr_t               a_x_addr;
        logic [7:0]          a_x_len;
        logic [2:0]          a_x_size;
        logic [1:0]          a_x_burst;
        logic [IdWidth-1:0]  a_x_id;
        logic [1:0]          x_resp;
        logic                x_last;
        logic [WayWidth-1:0] way_ind;
    } desc_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SPLIT = 1'b1
    } split_state_e;

    // Beats of the given size that still fit in the current line; 9 bits so a
    // line-aligned start with byte-sized beats cannot overflow.
    function automatic logic [8:0] beats_to_line_end(input logic [OffsetWidth-1:0] offset,
                                                     input logic [2:0] size);
        logic [8:0] bytes_left;
        bytes_left = 9'(LineBytes) - {{(9-OffsetWidth){1'b0}}, offset};
        return bytes_left >> size;
    endfunction

endpackage

// File: rtl/axi_llc_w_line_splitter.sv
// Cuts burst-level write descriptors into cache-line-bounded pieces for the LLC write unit.
// Only the final piece of each burst carries x_last so one B response is produced per burst.
module axi_llc_w_line_splitter
    import axi_llc_w_line_splitter_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_ni,
    input  desc_t desc_i,
    input  logic  desc_valid_i,
    output logic  desc_ready_o,
    output desc_t desc_o,
    output logic  desc_valid_o,
    input  logic  desc_ready_i,
    output logic  dbg_state_o
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid never drops and the payload never changes until then.

    split_state_e state_q, state_d;
    desc_t        desc_q;

    logic [8:0] beats_left;
    logic [8:0] rem;
    logic       burst_err;
    logic [7:0] piece_len;
    logic       last_piece;
    logic       out_hs;
    logic       in_hs;
    addr_t      next_line_addr;

    assign beats_left = beats_to_line_end(desc_q.a_x_addr[OffsetWidth-1:0], desc_q.a_x_size);
    assign rem        = {1'b0, desc_q.a_x_len} + 9'd1;
    assign burst_err  = (desc_q.a_x_burst == BurstWrap) || (desc_q.a_x_burst == 2'b11) ||
                        (desc_q.a_x_size > 3'(ByteOffsetLength));

    always_comb begin
        piece_len  = desc_q.a_x_len;
        last_piece = 1'b1;
        if (!burst_err && desc_q.a_x_burst == BurstIncr && rem > beats_left) begin
            piece_len  = 8'(beats_left - 9'd1);
            last_piece = 1'b0;
        end
    end

    assign out_hs         = (state_q == SPLIT) && desc_ready_i;
    assign in_hs          = desc_valid_i && desc_ready_o;
    assign next_line_addr = {desc_q.a_x_addr[AddrWidth-1:OffsetWidth], {OffsetWidth{1'b0}}}
                            + addr_t'(LineBytes);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_hs) state_d = SPLIT;
            SPLIT:   if (out_hs && last_piece) state_d = in_hs ? SPLIT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        desc_ready_o = 1'b0;
        desc_valid_o = 1'b0;
        desc_o       = desc_q;
        desc_o.a_x_len = piece_len;
        desc_o.x_last  = last_piece;
        if (burst_err) desc_o.x_resp = RespSlverr;
        case (state_q)
            IDLE:    desc_ready_o = 1'b1;
            SPLIT: begin
                desc_valid_o = 1'b1;
                desc_ready_o = desc_ready_i && last_piece;
            end
            default: desc_ready_o = 1'b0;
        endcase
    end

    // Non-final pieces restart at the next line boundary with the consumed beats removed.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            desc_q <= '0;
        end else if (in_hs) begin
            desc_q <= desc_i;
        end else if (out_hs && !last_piece) begin
            desc_q.a_x_addr <= next_line_addr;
            desc_q.a_x_len  <= desc_q.a_x_len - (piece_len + 8'd1);
        end
    end

    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_axi_llc_w_line_splitter.sv
// Directed bench for the line splitter: each scenario task drives vectors and checks inline.
module tb_axi_llc_w_line_splitter;
    import axi_llc_w_line_splitter_pkg::*;

    logic  clk_i;
    logic  rst_ni;
    desc_t desc_i;
    logic  desc_valid_i;
    logic  desc_ready_o;
    desc_t desc_o;
    logic  desc_valid_o;
    logic  desc_ready_i;
    logic  dbg_state_o;

    int checks;
    int errors;

    axi_llc_w_line_splitter dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .desc_i       (desc_i),
        .desc_valid_i (desc_valid_i),
        .desc_ready_o (desc_ready_o),
        .desc_o       (desc_o),
        .desc_valid_o (desc_valid_o),
        .desc_ready_i (desc_ready_i),
        .dbg_state_o  (dbg_state_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic desc_t mk(input logic [63:0] addr, input logic [7:0] len,
                                 input logic [2:0] size, input logic [1:0] burst,
                                 input logic [1:0] resp, input logic last);
        desc_t d;
        d.a_x_addr  = addr;
        d.a_x_len   = len;
        d.a_x_size  = size;
        d.a_x_burst = burst;
        d.a_x_id    = 4'h5;
        d.x_resp    = resp;
        d.x_last    = last;
        d.way_ind   = 8'h21;
        return d;
    endfunction

    task automatic step();
        @(negedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; desc_valid_i = 1'b0; desc_ready_i = 1'b1; desc_i = '0;
        repeat (2) step();
        checks++;
        if (desc_valid_o !== 1'b0 || desc_ready_o !== 1'b1 || dbg_state_o !== 1'b0) begin
            errors++;
            $display("FAIL reset: valid=%b ready=%b state=%b required 0 1 0",
                     desc_valid_o, desc_ready_o, dbg_state_o);
        end
        rst_ni = 1'b1;
        step();
    endtask

    task automatic test_incr_cross();
        desc_t e;
        @(negedge clk_i);
        desc_i = mk(64'h38, 8'd3, 3'd3, BurstIncr, RespOkay, 1'b1);
        desc_valid_i = 1'b1; desc_ready_i = 1'b1;
        #1;
        checks++;
        if (desc_ready_o !== 1'b1) begin
            errors++; $display("FAIL incr_idle_ready: got %b required 1", desc_ready_o);
        end
        @(negedge clk_i); desc_valid_i = 1'b0; #1;
        e = mk(64'h38, 8'd0, 3'd3, BurstIncr, RespOkay, 1'b0);
        checks++;
        if (desc_valid_o !== 1'b1 || desc_o !== e || desc_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL incr_piece0: v=%b rdy=%b got %h required %h", desc_valid_o, desc_ready_o, desc_o, e);
        end
        step();
        e = mk(64'h40, 8'd2, 3'd3, BurstIncr, RespOkay, 1'b1);
        checks++;
        if (desc_valid_o !== 1'b1 || desc_o !== e || desc_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL incr_piece1: v=%b rdy=%b got %h required %h", desc_valid_o, desc_ready_o, desc_o, e);
        end
        step();
        checks++;
        if (desc_valid_o !== 1'b0 || desc_ready_o !== 1'b1) begin
            errors++; $display("FAIL incr_done: v=%b rdy=%b required 0 1", desc_valid_o, desc_ready_o);
        end
    endtask

    task automatic test_incr_full_lines();
        desc_t e;
        @(negedge clk_i);
        desc_i = mk(64'h0, 8'd15, 3'd3, BurstIncr, RespSlverr, 1'b1);
        desc_valid_i = 1'b1; desc_ready_i = 1'b1;
        @(negedge clk_i); desc_valid_i = 1'b0; #1;
        e = mk(64'h0, 8'd7, 3'd3, BurstIncr, RespSlverr, 1'b0);
        checks++;
        if (desc_valid_o !== 1'b1 || desc_o !== e) begin
            errors++; $display("FAIL lines_piece0: got %h required %h", desc_o, e);
        end
        step();
        e = mk(64'h40, 8'd7, 3'd3, BurstIncr, RespSlverr, 1'b1);
        checks++;
        if (desc_valid_o !== 1'b1 || desc_o !== e) begin
            errors++; $display("FAIL lines_piece1: got %h required %h", desc_o, e);
        end
        step();
    endtask

    task automatic test_fixed();
        desc_t e;
        @(negedge clk_i);
        desc_i = mk(64'h3C, 8'd9, 3'd2, BurstFixed, RespOkay, 1'b0);
        desc_valid_i = 1'b1; desc_ready_i = 1'b1;
        @(negedge clk_i); desc_valid_i = 1'b0; #1;
        e = mk(64'h3C, 8'd9, 3'd2, BurstFixed, RespOkay, 1'b1);
        checks++;
        if (desc_valid_o !== 1'b1 || desc_o !== e || desc_ready_o !== 1'b1) begin
            errors++; $display("FAIL fixed_single: got %h required %h", desc_o, e);
        end
        step();
    endtask

    task automatic test_errors();
        desc_t e;
        @(negedge clk_i);
        desc_i = mk(64'h10, 8'd3, 3'd3, BurstWrap, RespOkay, 1'b0);
        desc_valid_i = 1'b1; desc_ready_i = 1'b1;
        @(negedge clk_i); desc_valid_i = 1'b0; #1;
        e = mk(64'h10, 8'd3, 3'd3, BurstWrap, RespSlverr, 1'b1);
        checks++;
        if (desc_valid_o !== 1'b1 || desc_o !== e) begin
            errors++; $display("FAIL wrap_slverr: got %h required %h", desc_o, e);
        end
        step();
        @(negedge clk_i);
        desc_i = mk(64'h0, 8'd1, 3'd4, BurstIncr, RespOkay, 1'b0);
        desc_valid_i = 1'b1;
        @(negedge clk_i); desc_valid_i = 1'b0; #1;
        e = mk(64'h0, 8'd1, 3'd4, BurstIncr, RespSlverr, 1'b1);
        checks++;
        if (desc_valid_o !== 1'b1 || desc_o !== e) begin
            errors++; $display("FAIL size_slverr: got %h required %h", desc_o, e);
        end
        step();
    endtask

    task automatic test_stall();
        desc_t e;
        @(negedge clk_i);
        desc_i = mk(64'h38, 8'd3, 3'd3, BurstIncr, RespOkay, 1'b0);
        desc_valid_i = 1'b1; desc_ready_i = 1'b0;
        @(negedge clk_i); desc_valid_i = 1'b0;
        e = mk(64'h38, 8'd0, 3'd3, BurstIncr, RespOkay, 1'b0);
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (desc_valid_o !== 1'b1 || desc_o !== e || desc_ready_o !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold[%0d]: v=%b got %h required %h", i, desc_valid_o, desc_o, e);
            end
            @(negedge clk_i);
        end
        desc_ready_i = 1'b1;
        #1;
        e = mk(64'h40, 8'd2, 3'd3, BurstIncr, RespOkay, 1'b1);
        step();
        checks++;
        if (desc_valid_o !== 1'b1 || desc_o !== e) begin
            errors++; $display("FAIL stall_release: got %h required %h", desc_o, e);
        end
        step();
    endtask

    task automatic test_back_to_back();
        desc_t e;
        @(negedge clk_i);
        desc_i = mk(64'h38, 8'd1, 3'd3, BurstIncr, RespOkay, 1'b0);
        desc_valid_i = 1'b1; desc_ready_i = 1'b1;
        @(negedge clk_i);
        desc_i = mk(64'h100, 8'd0, 3'd3, BurstIncr, RespOkay, 1'b0);
        #1;
        checks++;
        if (desc_ready_o !== 1'b0) begin
            errors++; $display("FAIL b2b_first_piece_ready: got %b required 0", desc_ready_o);
        end
        step();
        e = mk(64'h40, 8'd0, 3'd3, BurstIncr, RespOkay, 1'b1);
        checks++;
        if (desc_ready_o !== 1'b1 || desc_o !== e) begin
            errors++; $display("FAIL b2b_last_a: rdy=%b got %h required %h", desc_ready_o, desc_o, e);
        end
        @(negedge clk_i); desc_valid_i = 1'b0; #1;
        e = mk(64'h100, 8'd0, 3'd3, BurstIncr, RespOkay, 1'b1);
        checks++;
        if (desc_valid_o !== 1'b1 || desc_o !== e) begin
            errors++; $display("FAIL b2b_no_bubble: v=%b got %h required %h", desc_valid_o, desc_o, e);
        end
        step();
        checks++;
        if (desc_valid_o !== 1'b0) begin
            errors++; $display("FAIL b2b_idle: v=%b required 0", desc_valid_o);
        end
    endtask

    task automatic test_mid_reset();
        @(negedge clk_i);
        desc_i = mk(64'h0, 8'd15, 3'd3, BurstIncr, RespOkay, 1'b0);
        desc_valid_i = 1'b1; desc_ready_i = 1'b0;
        @(negedge clk_i); desc_valid_i = 1'b0; #1;
        checks++;
        if (desc_valid_o !== 1'b1) begin
            errors++; $display("FAIL midrst_pre: v=%b required 1", desc_valid_o);
        end
        #2 rst_ni = 1'b0;
        #1;
        checks++;
        if (desc_valid_o !== 1'b0 || desc_ready_o !== 1'b1 || dbg_state_o !== 1'b0) begin
            errors++;
            $display("FAIL midrst_async: v=%b rdy=%b state=%b required 0 1 0", desc_valid_o, desc_ready_o, dbg_state_o);
        end
        desc_ready_i = 1'b1;
        step();
        rst_ni = 1'b1;
        step();
        checks++;
        if (desc_valid_o !== 1'b0 || desc_ready_o !== 1'b1) begin
            errors++; $display("FAIL midrst_after: v=%b rdy=%b required 0 1", desc_valid_o, desc_ready_o);
        end
        test_incr_cross();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_incr_cross();
        test_incr_full_lines();
        test_fixed();
        test_errors();
        test_stall();
        test_back_to_back();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
